sumador_serial: RTL

SUMADOR_SERIAL -- requirements
Module: sumador_serial

---
 rtl/sumador_serial.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sumador_serial.sv
// Bit-serial unsigned adder: captures two ANCHO-bit operands, adds them one
// bit per clock (LSB first) through a single full adder, then presents the
// registered sum and carry-out together with a one-cycle listo pulse.
module sumador_serial #(
    parameter int ANCHO = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iniciar,
    input  logic [ANCHO-1:0] sumando_a,
    input  logic [ANCHO-1:0] sumando_b,
    output logic [ANCHO-1:0] suma,
    output logic             Cout,
    output logic             ocupado,
    output logic             listo
);

    // Counter must hold 0..ANCHO-1; one extra value of headroom keeps the
    // width sane for ANCHO = 1.
    localparam int CW = (ANCHO < 2) ? 1 : $clog2(ANCHO + 1);

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        SUMANDO = 2'd1,
        FIN     = 2'd2
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [ANCHO-1:0] a_q, a_d;
    logic [ANCHO-1:0] b_q, b_d;
    logic [ANCHO-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ANCHO-1:0] suma_q, suma_d;
    logic             cout_q, cout_d;

    // Single full adder working on the current operand LSBs and the carry.
    logic             bit_suma;
    logic             bit_carry;
    logic [ANCHO:0]   res_ext;
    logic             ultimo_bit;

    assign bit_suma   = a_q[0] ^ b_q[0] ^ carry_q;
    assign bit_carry  = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    // New sum bit enters from the MSB side; after ANCHO shifts the first
    // (LSB) result bit has travelled down to bit 0.
    assign res_ext    = {bit_suma, res_q};
    assign ultimo_bit = (cnt_q == CW'(ANCHO - 1));

    // Next-state and datapath control; every register holds by default.
    always_comb begin
        estado_d = estado_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        suma_d   = suma_q;
        cout_d   = cout_q;

        unique case (estado_q)
            REPOSO: begin
                if (iniciar) begin
                    a_d      = sumando_a;
                    b_d      = sumando_b;
                    carry_d  = 1'b0;
                    cnt_d    = '0;
                    estado_d = SUMANDO;
                end
            end
            SUMANDO: begin
                res_d   = res_ext[ANCHO:1];
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = bit_carry;
                cnt_d   = cnt_q + CW'(1);
                if (ultimo_bit) begin
                    // Publish the completed word on the same edge that
                    // shifts in its final bit.
                    suma_d   = res_ext[ANCHO:1];
                    cout_d   = bit_carry;
                    estado_d = FIN;
                end
            end
            FIN: begin
                // Requests arriving here are deliberately ignored.
                estado_d = REPOSO;
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= REPOSO;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            suma_q   <= '0;
            cout_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            suma_q   <= suma_d;
            cout_q   <= cout_d;
        end
    end

    // Moore status outputs decoded straight from the state register.
    assign ocupado = (estado_q != REPOSO);
    assign listo   = (estado_q == FIN);
    assign suma    = suma_q;
    assign Cout    = cout_q;

endmodule
